// File: rtl/adc_ring_writer_pkg.sv
// Shared AXI constants and write-helper status encodings for the ADC ring writer.
package adc_ring_writer_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_BRESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_BRESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_BRESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_BRESP_DECERR = 2'd3;

  // Status reported by the AXI-3 write helper.
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_OK    = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adc_ring_writer_if.sv
// Sample stream and write-helper request bundle. master = ring writer, slave = ADC source plus helper.
// Sample handshake: a word moves on a rising clock edge where s_valid && s_ready; s_data must hold while s_valid waits.
interface adc_ring_writer_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int BURST_LEN  = 16
);
  logic [BUS_WIDTH-1:0]           s_data;
  logic                           s_valid;
  logic                           s_ready;
  logic                           wr_enable;
  logic [ID_WIDTH-1:0]            wr_id;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [BURST_LEN*BUS_WIDTH-1:0] wr_data;
  logic [3:0]                     wr_burst_len;
  logic [2:0]                     wr_burst_size;
  logic [1:0]                     wr_burst_type;
  logic [BUS_WIDTH/8-1:0]         wr_strb;
  logic [1:0]                     wr_status;

  modport master (
    input  s_data, s_valid, wr_status,
    output s_ready, wr_enable, wr_id, wr_addr, wr_data, wr_burst_len,
           wr_burst_size, wr_burst_type, wr_strb
  );

  modport slave (
    output s_data, s_valid, wr_status,
    input  s_ready, wr_enable, wr_id, wr_addr, wr_data, wr_burst_len,
           wr_burst_size, wr_burst_type, wr_strb
  );
endinterface

// File: rtl/adc_burst_buf.sv
// Burst word packer: load writes din into the next slot (word 0 in LSBs); clear rewinds the slot counter.
module adc_burst_buf #(
  parameter int BUS_WIDTH = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           load,
  input  logic                           clear,
  input  logic [BUS_WIDTH-1:0]           din,
  output logic [BURST_LEN*BUS_WIDTH-1:0] data,
  output logic [CNT_W-1:0]               count,
  output logic                           full
);

  assign full = (count == CNT_W'(BURST_LEN));

  // Old slot contents survive clear; only the first count words are meaningful.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load && !full) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        if (count == CNT_W'(i)) data[i*BUS_WIDTH +: BUS_WIDTH] <= din;
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_ring_writer.sv
// Packs ADC words into bursts and writes them round-robin into a ring of HPS memory via the AXI-3 helper.
// Optional ADC_RING_IRQ_EN adds an irq pulse at the half-ring slot and at each wrap.
module adc_ring_writer
  import adc_ring_writer_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int BURST_LEN  = 16,
  parameter int TXN_ID     = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [15:0]           cfg_num_bursts,
  adc_ring_writer_if.master     bus,
  output logic                  busy,
  output logic [15:0]           burst_idx,
  output logic [15:0]           wrap_count,
  output logic [7:0]            err_count,
  output logic                  last_err,
  output logic [1:0]            dbg_state
`ifdef ADC_RING_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int CNT_W       = $clog2(BURST_LEN + 1);
  localparam int BURST_BYTES = BURST_LEN * BUS_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT} state_t;

  state_t                         state, state_d;
  logic [ADDR_WIDTH-1:0]          base_q, wr_addr_q, slot_addr;
  logic [15:0]                    num_q;
  logic [3:0]                     wr_len_q, issue_len;
  logic                           stop_pending;
  logic                           buf_load, buf_clear, buf_full;
  logic [CNT_W-1:0]               buf_count, cnt_next;
  logic [BURST_LEN*BUS_WIDTH-1:0] buf_data;
  logic                           run_start, issue_go, done, last_slot;

  adc_burst_buf #(.BUS_WIDTH(BUS_WIDTH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .din     (bus.s_data),
    .data    (buf_data),
    .count   (buf_count),
    .full    (buf_full)
  );

  assign cnt_next  = buf_count + CNT_W'(buf_load);
  assign slot_addr = base_q + ADDR_WIDTH'(burst_idx) * ADDR_WIDTH'(BURST_BYTES);
  assign last_slot = (burst_idx == num_q - 16'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d     = state;
    bus.s_ready = 1'b0;
    bus.wr_enable = 1'b0;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    run_start   = 1'b0;
    issue_go    = 1'b0;
    issue_len   = 4'(BURST_LEN - 1);
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && cfg_num_bursts != 16'd0) begin
          run_start = 1'b1;
          buf_clear = 1'b1;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        bus.s_ready = !buf_full;
        buf_load    = bus.s_valid && !buf_full;
        // A word accepted alongside stop still belongs to the flushed burst.
        if (stop) begin
          issue_len = 4'(cnt_next - CNT_W'(1));
          state_d   = (cnt_next != '0) ? S_ISSUE : S_IDLE;
        end else if (cnt_next == CNT_W'(BURST_LEN)) begin
          state_d = S_ISSUE;
        end
        issue_go = (state_d == S_ISSUE);
      end
      S_ISSUE: begin
        if (bus.wr_status == ST_READY) begin
          bus.wr_enable = 1'b1;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.wr_status == ST_OK || bus.wr_status == ST_ERR) begin
          done      = 1'b1;
          buf_clear = 1'b1;
          state_d   = (stop_pending || stop) ? S_IDLE : S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      num_q        <= '0;
      wr_addr_q    <= '0;
      wr_len_q     <= '0;
      stop_pending <= 1'b0;
      burst_idx    <= '0;
      wrap_count   <= '0;
      err_count    <= '0;
      last_err     <= 1'b0;
    end else begin
      if (run_start) begin
        base_q       <= cfg_base;
        num_q        <= cfg_num_bursts;
        burst_idx    <= '0;
        last_err     <= 1'b0;
        stop_pending <= 1'b0;
      end
      if (issue_go) begin
        wr_addr_q <= slot_addr;
        wr_len_q  <= issue_len;
      end
      if (stop && (issue_go || state == S_ISSUE || state == S_WAIT)) stop_pending <= 1'b1;
      // Errors are counted but never retried; the ring keeps advancing.
      if (done) begin
        stop_pending <= 1'b0;
        if (bus.wr_status == ST_ERR) begin
          err_count <= sat_inc8(err_count);
          last_err  <= 1'b1;
        end
        if (last_slot) begin
          burst_idx  <= '0;
          wrap_count <= wrap_count + 16'd1;
        end else begin
          burst_idx <= burst_idx + 16'd1;
        end
      end
    end
  end

`ifdef ADC_RING_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= done && (last_slot || (num_q != 16'd1 && burst_idx == (num_q >> 1)));
  end
`endif

  assign busy              = (state != S_IDLE);
  assign dbg_state         = state;
  assign bus.wr_id         = ID_WIDTH'(TXN_ID);
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = buf_data;
  assign bus.wr_burst_len  = wr_len_q;
  assign bus.wr_burst_size = 3'($clog2(BUS_WIDTH / 8));
  assign bus.wr_burst_type = AXI_BURST_INCR;
  assign bus.wr_strb       = {(BUS_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_adc_ring_writer.sv
// Directed bench for adc_ring_writer with a behavioural write helper and a burst scoreboard.
module tb_adc_ring_writer;
  import adc_ring_writer_pkg::*;

  localparam int BW = 32;
  localparam int BL = 4;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam logic [1:0] D_IDLE = 2'd0, D_FILL = 2'd1, D_WAIT = 2'd3;
  localparam logic [AW-1:0] BASE = 32'h3000_0000;
  localparam logic [BL*BW-1:0] ALL = {(BL*BW){1'b1}};
  localparam logic [BL*BW-1:0] LOW3 = {{BW{1'b0}}, {(3*BW){1'b1}}};

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [15:0] cfg_num_bursts = '0;
  logic busy, last_err;
  logic [15:0] burst_idx, wrap_count;
  logic [7:0] err_count;
  logic [1:0] dbg_state;
`ifdef ADC_RING_IRQ_EN
  logic irq;
  int irq_hist[$];
  int got_base = 0;
`endif

  adc_ring_writer_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BURST_LEN(BL)) bus ();

  adc_ring_writer #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BURST_LEN(BL), .TXN_ID(8'h5A)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .cfg_base       (cfg_base),
    .cfg_num_bursts (cfg_num_bursts),
    .bus            (bus),
    .busy           (busy),
    .burst_idx      (burst_idx),
    .wrap_count     (wrap_count),
    .err_count      (err_count),
    .last_err       (last_err),
    .dbg_state      (dbg_state)
`ifdef ADC_RING_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int err_bursts = 0;
  int got_total = 0;
  logic [AW-1:0]    got_addr[$];
  logic [3:0]       got_len[$];
  logic [BL*BW-1:0] got_data[$];
  logic [AW-1:0]    exp_addr_q[$];
  logic [3:0]       exp_len_q[$];
  logic [BL*BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural helper: accepts a request, reports wait, then ok (or err while err_bursts > 0).
  initial begin
    bus.wr_status = ST_READY;
    forever begin
      @(posedge clock); #1;
      if (reset_n && bus.wr_enable) begin
        got_addr.push_back(bus.wr_addr);
        got_len.push_back(bus.wr_burst_len);
        got_data.push_back(bus.wr_data);
        got_total++;
        @(posedge clock); #1;
        bus.wr_status = ST_WAIT;
        check("wait_state", dbg_state, D_WAIT);
        check("s_ready_in_wait", bus.s_ready, 1'b0);
        @(posedge clock); #1;
        if (err_bursts > 0) begin
          err_bursts--;
          bus.wr_status = ST_ERR;
        end else begin
          bus.wr_status = ST_OK;
        end
        @(posedge clock); #1;
        bus.wr_status = ST_READY;
      end
    end
  end

`ifdef ADC_RING_IRQ_EN
  initial forever begin
    @(negedge clock);
    if (irq) irq_hist.push_back(got_total - got_base);
  end
`endif

  // driver tasks
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start_run(input logic [AW-1:0] base, input logic [15:0] num);
    cfg_base = base;
    cfg_num_bursts = num;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [BW-1:0] d);
    int n = 0;
    bus.s_data = d;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("send_ready", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 200) begin
      tick();
      n++;
    end
    check(tag, dbg_state, s);
  endtask

  task automatic expect_burst(input logic [AW-1:0] a, input logic [3:0] len, input logic [BL*BW-1:0] d);
    exp_addr_q.push_back(a);
    exp_len_q.push_back(len);
    exp_q.push_back(d);
  endtask

  // scoreboard: compare captured helper requests with the expected queue
  task automatic score(input string tag, input logic [BL*BW-1:0] mask);
    check({tag, "_count"}, got_addr.size(), exp_addr_q.size());
    while (exp_addr_q.size() > 0 && got_addr.size() > 0) begin
      check({tag, "_addr"}, got_addr.pop_front(), exp_addr_q.pop_front());
      check({tag, "_len"}, got_len.pop_front(), exp_len_q.pop_front());
      check({tag, "_data"}, got_data.pop_front() & mask, exp_q.pop_front() & mask);
    end
    exp_addr_q.delete(); exp_len_q.delete(); exp_q.delete();
    got_addr.delete(); got_len.delete(); got_data.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_state"}, dbg_state, D_IDLE);
    check({tag, "_s_ready"}, bus.s_ready, 1'b0);
    check({tag, "_wr_enable"}, bus.wr_enable, 1'b0);
    check({tag, "_burst_idx"}, burst_idx, 16'd0);
    check({tag, "_wrap"}, wrap_count, 16'd0);
    check({tag, "_err"}, err_count, 8'd0);
    check({tag, "_last_err"}, last_err, 1'b0);
    check({tag, "_wr_addr"}, bus.wr_addr, '0);
    check({tag, "_wr_data"}, bus.wr_data, '0);
    check({tag, "_wr_len"}, bus.wr_burst_len, 4'd0);
  endtask

  initial begin
    int saved;
    bus.s_valid = 1'b0;
    bus.s_data = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    check("reset_wr_id", bus.wr_id, 8'h5A);
    check("reset_burst_size", bus.wr_burst_size, 3'd2);
    check("reset_burst_type", bus.wr_burst_type, 2'd1);
    check("reset_strb", bus.wr_strb, 4'hF);
    reset_n = 1'b1;
    tick();

    // two full bursts around a 2-slot ring
    start_run(BASE, 16'd2);
    for (int i = 1; i <= 8; i++) begin
      send_word(BW'(i));
      if (i % 4 == 0) check("latency_wr_enable", bus.wr_enable, 1'b1);
    end
    expect_burst(BASE, 4'd3, 128'h00000004_00000003_00000002_00000001);
    expect_burst(BASE + 32'h10, 4'd3, 128'h00000008_00000007_00000006_00000005);
    wait_state(D_FILL, "run1_refill");
    score("run1", ALL);
    check("run1_burst_idx", burst_idx, 16'd0);
    check("run1_wrap", wrap_count, 16'd1);
    check("run1_err", err_count, 8'd0);
    pulse_stop();
    check("stop_empty_busy", busy, 1'b0);
    saved = got_total;
    repeat (5) tick();
    check("stop_empty_no_enable", got_total, saved);

    // stop after 3 words flushes a short burst
    start_run(BASE, 16'd2);
    send_word(32'hA1); send_word(32'hA2); send_word(32'hA3);
    pulse_stop();
    check("stop_partial_issue", bus.wr_enable, 1'b1);
    expect_burst(BASE, 4'd2, 128'h0_000000A3_000000A2_000000A1);
    wait_state(D_IDLE, "stop_partial_idle");
    score("stop3", LOW3);
    check("stop3_burst_idx", burst_idx, 16'd1);

    // stop with no words, and start with zero ring size
    saved = got_total;
    start_run(BASE, 16'd2);
    check("start_busy", busy, 1'b1);
    pulse_stop();
    check("stop0_idle", busy, 1'b0);
    start_run(BASE, 16'd0);
    check("num0_ignored", busy, 1'b0);
    repeat (5) tick();
    check("stop0_no_enable", got_total, saved);

    // error on first burst: counted, address still advances
    start_run(BASE, 16'd2);
    check("restart_burst_idx", burst_idx, 16'd0);
    err_bursts = 1;
    for (int i = 1; i <= 8; i++) send_word(32'hB0 + BW'(i));
    expect_burst(BASE, 4'd3, 128'h000000B4_000000B3_000000B2_000000B1);
    expect_burst(BASE + 32'h10, 4'd3, 128'h000000B8_000000B7_000000B6_000000B5);
    wait_state(D_FILL, "err_refill");
    score("err1", ALL);
    check("err1_count", err_count, 8'd1);
    check("err1_last_err", last_err, 1'b1);
    check("err1_wrap", wrap_count, 16'd2);
    pulse_stop();
    wait_state(D_IDLE, "err1_idle");

    // error counter saturation
    start_run(BASE, 16'd2);
    check("last_err_cleared", last_err, 1'b0);
    err_bursts = 300;
    for (int i = 0; i < 1200; i++) send_word(BW'($urandom_range(0, 32'hFFFF)));
    wait_state(D_FILL, "sat_refill");
    check("sat_err_count", err_count, 8'd255);
    check("sat_last_err", last_err, 1'b1);
    check("sat_wrap", wrap_count, 16'd152);
    check("sat_burst_idx", burst_idx, 16'd0);
    check("sat_bursts", got_addr.size(), 300);
    got_addr.delete(); got_len.delete(); got_data.delete();
    pulse_stop();
    wait_state(D_IDLE, "sat_idle");

    // s_valid held through ISSUE/WAIT, then stop together with the 4th word
    start_run(BASE, 16'd2);
    for (int i = 1; i <= 8; i++) send_word(32'hC0 + BW'(i));
    expect_burst(BASE, 4'd3, 128'h000000C4_000000C3_000000C2_000000C1);
    expect_burst(BASE + 32'h10, 4'd3, 128'h000000C8_000000C7_000000C6_000000C5);
    wait_state(D_FILL, "held_refill");
    score("held", ALL);
    send_word(32'hD1); send_word(32'hD2); send_word(32'hD3);
    bus.s_data = 32'hD4;
    bus.s_valid = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    bus.s_valid = 1'b0;
    check("stop_same_issue", bus.wr_enable, 1'b1);
    expect_burst(BASE, 4'd3, 128'h000000D4_000000D3_000000D2_000000D1);
    wait_state(D_IDLE, "stop_same_idle");
    score("stop_same", ALL);

    // asynchronous reset while waiting on the helper
    start_run(BASE, 16'd2);
    for (int i = 1; i <= 4; i++) send_word(32'hE0 + BW'(i));
    wait_state(D_WAIT, "rst_wait");
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b1;
    got_addr.delete(); got_len.delete(); got_data.delete();
    tick();
    start_run(BASE + 32'h100, 16'd2);
    for (int i = 1; i <= 4; i++) send_word(32'hF0 + BW'(i));
    expect_burst(BASE + 32'h100, 4'd3, 128'h000000F4_000000F3_000000F2_000000F1);
    wait_state(D_FILL, "post_rst_refill");
    score("post_rst", ALL);
    check("post_rst_burst_idx", burst_idx, 16'd1);
    pulse_stop();
    wait_state(D_IDLE, "post_rst_idle");

`ifdef ADC_RING_IRQ_EN
    // irq after slot 2 and at wrap of a 4-slot ring
    irq_hist.delete();
    got_base = got_total;
    start_run(BASE, 16'd4);
    for (int i = 0; i < 16; i++) send_word(BW'(i));
    wait_state(D_FILL, "irq_refill");
    repeat (3) tick();
    check("irq_pulses", irq_hist.size(), 2);
    if (irq_hist.size() == 2) begin
      check("irq_half", irq_hist[0], 3);
      check("irq_wrap", irq_hist[1], 4);
    end
    got_addr.delete(); got_len.delete(); got_data.delete();
    pulse_stop();
    wait_state(D_IDLE, "irq_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc_ring_writer.md
Name: adc_ring_writer

Overview:
Sequencer between the ADC sample stream and the AXI-3 write helper on the F2H bridge. Packs incoming bus-width words into a burst buffer and launches one helper transaction per full buffer. Advances the write address through a ring region in HPS memory and reports progress and error counters to software-visible registers.

Parameters:
ID_WIDTH, 8, AXI transaction ID width
ADDR_WIDTH, 32, AXI address width
BUS_WIDTH, 32, AXI data width in bits (8..1024, power of 2)
BURST_LEN, 16, words per burst (1..16)
TXN_ID, 0, constant ID driven to helper

Ports:
clock  in  1  system clock
reset_n  in  1  async active-low reset
start  in  1  pulse: latch cfg, begin run
stop  in  1  pulse: flush partial burst, end run
cfg_base  in  ADDR_WIDTH  ring base address, burst-aligned
cfg_num_bursts  in  16  ring size in bursts
s_data  in  BUS_WIDTH  sample word
s_valid  in  1  s_data valid
s_ready  out  1  word accepted when s_valid&&s_ready
wr_enable  out  1  helper start request
wr_id  out  ID_WIDTH  =TXN_ID
wr_addr  out  ADDR_WIDTH  burst start address
wr_data  out  BURST_LEN*BUS_WIDTH  burst buffer, word0 in LSBs
wr_burst_len  out  4  transfers-1
wr_burst_size  out  3  constant log2(BUS_WIDTH/8)
wr_burst_type  out  2  constant 1 (INCR)
wr_strb  out  BUS_WIDTH/8  all ones
wr_status  in  2  helper status: 0 ready, 1 wait, 2 ok, 3 error
busy  out  1  state != IDLE
burst_idx  out  16  ring slot of next burst
wrap_count  out  16  ring wraps, modulo 2^16
err_count  out  8  helper errors, saturating at 255
last_err  out  1  set on status 3, cleared on start

Behaviour:
- Reset: every output and register 0, except wr_id/wr_burst_size/wr_burst_type/wr_strb constants. State IDLE.
- States: IDLE, FILL, ISSUE, WAIT.
- IDLE: start && cfg_num_bursts!=0 -> latch base/num, burst_idx=0, word_cnt=0, clear last_err, FILL. start with num==0 ignored.
- FILL: s_ready=1. Handshake writes s_data into slot word_cnt, word_cnt++. When word_cnt reaches BURST_LEN -> ISSUE, wr_burst_len=BURST_LEN-1.
- stop in FILL (stop_pending also set): same-cycle handshake word is kept.
  - word_cnt (incl. that word) >0 -> ISSUE with wr_burst_len=word_cnt-1.
  - otherwise -> IDLE.
- stop in ISSUE/WAIT sets stop_pending. start outside IDLE ignored.
- ISSUE: wr_enable=1 for exactly one cycle (only when wr_status==0, else hold ISSUE) -> WAIT. s_ready=0.
- WAIT: s_ready=0. Buffer, wr_addr and wr_burst_len held stable; helper indexes wr_data live.
  - Status 1 ignored.
  - Status 2 or 3 -> 3: err_count sat++, last_err=1.
  - In both cases: burst_idx++, wrapping to 0 at num-1 with wrap_count++; word_cnt=0.
  - Next state: IDLE if stop_pending (cleared), else FILL. Address still advances on error; no retry.
- wr_addr = base + burst_idx*BURST_LEN*BUS_WIDTH/8, computed at ADDR_WIDTH, registered on entry to ISSUE.
- Run latency: last word accepted -> wr_enable high next cycle.
- Reset mid-burst aborts everything. The helper shares reset_n.

Optional Feature:
ADC_RING_IRQ_EN: adds output irq (1 bit), a one-cycle pulse on each completion that wraps burst_idx to 0, and on the completion of slot num/2 (integer division; skipped when num==1). Without the macro, no irq port and no extra logic.

Decomposition:
- Shared package/header axi_def.vh: AXI_BURST_INCR, AXI_BRESP_* constants, helper status encodings ST_READY/ST_WAIT/ST_OK/ST_ERR.
- Local state encoding stays in the module.
- One natural sub-module, adc_burst_buf: word packer with slot counter, load/clear and full flag.

Test Plan:
- BURST_LEN=4, base=0x3000_0000, num=2, 8 words 0x1..0x8 with ideal helper -> two bursts at 0x3000_0000 and 0x3000_0010, data 0x4_3_2_1 then 0x8_7_6_5, burst_len=3; after the second, burst_idx=0 and wrap_count=1.
- Stop after 3 words -> one burst with burst_len=2 then IDLE. Stop with 0 words -> IDLE, no wr_enable.
- Helper returns status 3 on the first burst -> err_count=1, last_err=1, second burst still issued at 0x3000_0010. Force 300 errors -> err_count=255.
- s_valid held high during WAIT -> s_ready=0, no words lost or duplicated. Stop in the same cycle as the 4th word -> full burst issued, then IDLE.
- Assert reset_n low during WAIT -> all outputs 0 asynchronously. Restart -> first burst at base.
- With ADC_RING_IRQ_EN, num=4 -> irq pulses after slot 2 and at wrap, each 1 cycle wide.
